load_use_scoreboard: RTL and testbench
======================================

Name: load_use_scoreboard

Overview:
Parametrised load-use hazard unit for the pipelined CPU. It replaces single-cycle Rd/rs comparison with a per-register countdown scoreboard, so data-memory latencies longer than one cycle stall dependents for exactly the right number of cycles. It sits beside the ID stage, watches instructions leaving ID, and drives PC/IF-ID hold and the ID/EX bubble. It also provides a global freeze input for cache misses and a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register index width; register count is 2**REG_ADDR_W
LOAD_LAT, 1, cycles after a load enters EX during which a consumer in ID must stall; 1 = classic 5-stage with forwarding
PERF_W, 16, stall-cycle counter width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low
id_valid_i  in  1  ID stage holds a real instruction
id_mem_read_i  in  1  ID instruction is a load
id_reg_write_i  in  1  ID instruction writes Rd
id_rd_i  in  REG_ADDR_W  ID destination register
id_rs1_i  in  REG_ADDR_W  ID source 1
id_rs2_i  in  REG_ADDR_W  ID source 2
id_rs1_used_i  in  1  rs1 is actually read
id_rs2_used_i  in  1  rs2 is actually read
flush_i  in  1  taken branch: ID instruction is squashed this cycle
freeze_i  in  1  global pipeline hold (memory miss)
stall_o  out  1  hold PC and IF/ID, bubble ID/EX
hazard_src_o  out  2  bit0: rs1 blocked, bit1: rs2 blocked
busy_o  out  1  any scoreboard entry nonzero
stall_cycles_o  out  PERF_W  saturating count of stall cycles

Behaviour:
- State: one counter cnt[r] per register, width clog2(LOAD_LAT+1). Also the perf counter.
- Reset (rst_i=0 at an edge): all cnt to 0 and stall_cycles_o to 0. stall_o, hazard_src_o and busy_o are therefore 0 right after reset. Reset overrides every other input, including mid-countdown.
- hazard_src_o[0] = id_valid_i & id_rs1_used_i & (id_rs1_i!=0) & (cnt[id_rs1_i]!=0). Bit1 is the same for rs2.
- stall_o = |hazard_src_o. It is combinational from registered state and ID inputs, with no extra latency.
- busy_o = OR of all cnt!=0.
- issue = id_valid_i & id_mem_read_i & id_reg_write_i & (id_rd_i!=0) & ~stall_o & ~flush_i & ~freeze_i.
- Per-edge update, with freeze_i=0:
  - If issue, cnt[id_rd_i] <= LOAD_LAT.
  - Every other nonzero cnt decrements by 1.
  - If issue targets an entry that is also counting down, the reload wins (no decrement that cycle).
- With freeze_i=1: all cnt hold and no issue is recorded. stall_o is still computed and driven.
- x0 is never tracked and never causes a stall.
- Non-load writers never set an entry. A later non-load write to the same Rd does not clear a pending entry (conservative).
- flush_i blocks recording of the squashed ID instruction only. Entries for older loads keep counting.
- Perf counter: stall_cycles_o increments when stall_o & ~freeze_i, saturates at all-ones, and never wraps.
- Equivalence: with LOAD_LAT=1, a consumer directly after a load stalls exactly 1 cycle, matching the existing single-cycle unit.
- Stall timing: a dependent at distance d behind the load (d=1 means adjacent) stalls max(0, LOAD_LAT-d+1) cycles, not counting freeze cycles.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with a load to x5 in ID -> after release stall_o=0, busy_o=0, stall_cycles_o=0. Scoreboard entries stay 0 because issue is not recorded during reset.
- LOAD_LAT=1: issue lw x5, then add x6,x5,x7 next cycle -> stall_o=1 for exactly 1 cycle, hazard_src_o=01, stall_cycles_o=1. With rs2=x5 instead -> hazard_src_o=10.
- LOAD_LAT=3: lw x5; an independent instruction; then a use of x5 (d=2) -> 2 stall cycles. Adjacent use (d=1) -> 3 stall cycles. Use at d=4 -> no stall.
- freeze_i: LOAD_LAT=3, adjacent consumer stalled with cnt=2, assert freeze_i for 4 cycles -> cnt holds at 2, stall_o stays 1, stall_cycles_o unchanged. After release -> 2 more stall cycles.
- flush_i with a load in ID -> nothing recorded, busy_o stays 0, the next consumer does not stall. A load targeting x0 -> never recorded.
- Reload/saturation: LOAD_LAT=3, lw x5 twice back-to-back -> cnt[x5] is reloaded to 3 on the second issue. With PERF_W=4, stall for 20 cycles -> stall_cycles_o=15 and it holds there.

Source files
------------

// File: rtl/load_use_scoreboard_if.sv
// ---------------------------------------------------------------------------
// load_use_scoreboard_if
//   Bundles the ID-stage observation signals and the hazard-unit responses
//   of the load-use scoreboard into one interface.
//
//   Decode side (driven by the pipeline / master):
//     id_valid_i      ID stage holds a real instruction
//     id_mem_read_i   ID instruction is a load
//     id_reg_write_i  ID instruction writes Rd
//     id_rd_i         ID destination register
//     id_rs1_i        ID source 1
//     id_rs2_i        ID source 2
//     id_rs1_used_i   rs1 is actually read
//     id_rs2_used_i   rs2 is actually read
//     flush_i         ID instruction squashed this cycle
//     freeze_i        global pipeline hold
//   Hazard side (driven by the scoreboard / slave):
//     stall_o         hold PC and IF/ID, bubble ID/EX
//     hazard_src_o    bit0 rs1 blocked, bit1 rs2 blocked
//     busy_o          any scoreboard entry still counting
//     stall_cycles_o  saturating stall-cycle count
// ---------------------------------------------------------------------------
interface load_use_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 16
);
  logic                  id_valid_i;
  logic                  id_mem_read_i;
  logic                  id_reg_write_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_rs1_used_i;
  logic                  id_rs2_used_i;
  logic                  flush_i;
  logic                  freeze_i;
  logic                  stall_o;
  logic [1:0]            hazard_src_o;
  logic                  busy_o;
  logic [PERF_W-1:0]     stall_cycles_o;

  modport master (
    output id_valid_i, id_mem_read_i, id_reg_write_i, id_rd_i,
           id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           flush_i, freeze_i,
    input  stall_o, hazard_src_o, busy_o, stall_cycles_o
  );

  modport slave (
    input  id_valid_i, id_mem_read_i, id_reg_write_i, id_rd_i,
           id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           flush_i, freeze_i,
    output stall_o, hazard_src_o, busy_o, stall_cycles_o
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// ---------------------------------------------------------------------------
// load_use_scoreboard
//   Load-use hazard unit with one countdown entry per architectural register.
//   A load leaving ID loads its Rd entry with LOAD_LAT; the entry ticks down
//   once per unfrozen cycle, and any ID consumer of a register whose entry is
//   nonzero is held in ID. Also keeps a saturating count of stall cycles.
//
//   Ports:
//     clk_i  rising-edge clock
//     rst_i  synchronous, active-low reset (clears entries and perf counter)
//     bus    load_use_scoreboard_if.slave: ID-stage inputs, flush/freeze,
//            stall_o / hazard_src_o / busy_o / stall_cycles_o outputs
// ---------------------------------------------------------------------------
module load_use_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int PERF_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  load_use_scoreboard_if.slave  bus
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  // Entry width large enough to hold LOAD_LAT itself.
  localparam int CNT_W    = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [REG_ADDR_W-1:0] REG_X0   = REG_ADDR_W'(0);
  localparam logic [PERF_W-1:0]     PERF_MAX = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0]     PERF_ONE = PERF_W'(1);

  logic [CNT_W-1:0]  cnt_r [NUM_REGS];
  logic [PERF_W-1:0] stall_cycles_r;

  logic [1:0] hazard_src_s;
  logic       stall_s;
  logic       busy_s;
  logic       issue_s;

  // Source-operand blocking and load-issue qualification for the ID instruction
  always_comb begin
    hazard_src_s    = 2'b00;
    hazard_src_s[0] = bus.id_valid_i & bus.id_rs1_used_i &
                      (bus.id_rs1_i != REG_X0) & (cnt_r[bus.id_rs1_i] != CNT_ZERO);
    hazard_src_s[1] = bus.id_valid_i & bus.id_rs2_used_i &
                      (bus.id_rs2_i != REG_X0) & (cnt_r[bus.id_rs2_i] != CNT_ZERO);
    stall_s         = |hazard_src_s;
    // A stalled, squashed or frozen load is not the one that reaches EX.
    issue_s         = bus.id_valid_i & bus.id_mem_read_i & bus.id_reg_write_i &
                      (bus.id_rd_i != REG_X0) & ~stall_s & ~bus.flush_i & ~bus.freeze_i;
  end

  // Any outstanding load result anywhere in the register file
  always_comb begin
    busy_s = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_s = busy_s | (cnt_r[r] != CNT_ZERO);
    end
  end

  // Per-register countdown: reset clears, freeze holds, issue reloads, others tick down
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
    end else if (bus.freeze_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_r[r];
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == 0) begin
          // x0 is never tracked.
          cnt_r[r] <= CNT_ZERO;
        end else if (issue_s && (bus.id_rd_i == REG_ADDR_W'(r))) begin
          // Reload takes priority over the decrement of a live entry.
          cnt_r[r] <= CNT_LOAD;
        end else if (cnt_r[r] != CNT_ZERO) begin
          cnt_r[r] <= cnt_r[r] - CNT_ONE;
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end
  end

  // Saturating count of cycles lost to load-use stalls (frozen cycles excluded)
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cycles_r <= {PERF_W{1'b0}};
    end else if (stall_s && !bus.freeze_i && (stall_cycles_r != PERF_MAX)) begin
      stall_cycles_r <= stall_cycles_r + PERF_ONE;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  // stall/hazard must act in the same cycle the consumer sits in ID, so they
  // are decoded from registered state rather than registered again.
  assign bus.stall_o        = stall_s;
  assign bus.hazard_src_o   = hazard_src_s;
  assign bus.busy_o         = busy_s;
  assign bus.stall_cycles_o = stall_cycles_r;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_load_use_scoreboard
//   Two scoreboards (LOAD_LAT=1/PERF_W=16 and LOAD_LAT=3/PERF_W=4) see the
//   same ID stream. The reference model tracks, per register, the cycle at
//   which a loaded value becomes usable; expected outputs are queued by the
//   stimulus process and compared at the falling edge by a monitor.
// ---------------------------------------------------------------------------
module tb_load_use_scoreboard;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  load_use_scoreboard_if #(.REG_ADDR_W(5), .PERF_W(16)) bus_a ();
  load_use_scoreboard_if #(.REG_ADDR_W(5), .PERF_W(4))  bus_b ();

  load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .PERF_W(16)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_a.slave)
  );

  load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3), .PERF_W(4)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_b.slave)
  );

  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic       mr;
    logic       rw;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       flush;
    logic       freeze;
  } stim_t;

  typedef struct {
    int         cyc;
    logic [1:0] hz_a;
    logic [1:0] hz_b;
    logic       busy_a;
    logic       busy_b;
    int         perf_a;
    int         perf_b;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: ready_at[d][r] = active-cycle index from which r is usable.
  int ready_at [2][32];
  int now_c = 0;
  int perf_c [2];
  int lat_c [2]    = '{1, 3};
  int perf_max [2] = '{65535, 15};
  bit primed = 1'b0;
  int cyc = 0;

  int checks = 0;
  int errors = 0;

  function automatic logic [1:0] model_hz(input int d, input stim_t s);
    logic [1:0] h;
    h[0] = s.valid && s.u1 && (s.rs1 != 5'd0) && (now_c < ready_at[d][s.rs1]);
    h[1] = s.valid && s.u2 && (s.rs2 != 5'd0) && (now_c < ready_at[d][s.rs2]);
    return h;
  endfunction

  function automatic logic model_busy(input int d);
    for (int r = 1; r < 32; r++) begin
      if (ready_at[d][r] > now_c) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_edge(input stim_t s);
    logic stall;
    if (!s.rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 32; r++) ready_at[d][r] = 0;
        perf_c[d] = 0;
      end
      now_c = 0;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      stall = |model_hz(d, s);
      if (stall && !s.freeze && perf_c[d] < perf_max[d]) perf_c[d]++;
      if (!s.freeze && !stall && !s.flush && s.valid && s.mr && s.rw && s.rd != 5'd0)
        ready_at[d][s.rd] = now_c + lat_c[d] + 1;
    end
    if (!s.freeze) now_c++;
  endfunction

  function automatic stim_t mk(input logic mr, input logic rw, input int rd,
                               input int rs1, input int rs2, input logic u1, input logic u2);
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    s.valid = 1'b1;
    s.mr    = mr;
    s.rw    = rw;
    s.rd    = 5'(rd);
    s.rs1   = 5'(rs1);
    s.rs2   = 5'(rs2);
    s.u1    = u1;
    s.u2    = u2;
    return s;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // Drive one cycle of ID inputs, queue the expected response, advance the model.
  task automatic apply(input stim_t s);
    exp_t e;
    rst_n = s.rst_n;
    bus_a.id_valid_i = s.valid;  bus_b.id_valid_i = s.valid;
    bus_a.id_mem_read_i = s.mr;  bus_b.id_mem_read_i = s.mr;
    bus_a.id_reg_write_i = s.rw; bus_b.id_reg_write_i = s.rw;
    bus_a.id_rd_i = s.rd;        bus_b.id_rd_i = s.rd;
    bus_a.id_rs1_i = s.rs1;      bus_b.id_rs1_i = s.rs1;
    bus_a.id_rs2_i = s.rs2;      bus_b.id_rs2_i = s.rs2;
    bus_a.id_rs1_used_i = s.u1;  bus_b.id_rs1_used_i = s.u1;
    bus_a.id_rs2_used_i = s.u2;  bus_b.id_rs2_used_i = s.u2;
    bus_a.flush_i = s.flush;     bus_b.flush_i = s.flush;
    bus_a.freeze_i = s.freeze;   bus_b.freeze_i = s.freeze;
    if (primed) begin
      e.cyc    = cyc;
      e.hz_a   = model_hz(0, s);
      e.hz_b   = model_hz(1, s);
      e.busy_a = model_busy(0);
      e.busy_b = model_busy(1);
      e.perf_a = perf_c[0];
      e.perf_b = perf_c[1];
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge(s);
    primed = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs with the queued expectation away from the clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_hazard_src", e.cyc, 32'(bus_a.hazard_src_o), 32'(e.hz_a));
        chk("a_stall", e.cyc, 32'(bus_a.stall_o), 32'(|e.hz_a));
        chk("a_busy", e.cyc, 32'(bus_a.busy_o), 32'(e.busy_a));
        chk("a_stall_cycles", e.cyc, 32'(bus_a.stall_cycles_o), 32'(e.perf_a));
        chk("b_hazard_src", e.cyc, 32'(bus_b.hazard_src_o), 32'(e.hz_b));
        chk("b_stall", e.cyc, 32'(bus_b.stall_o), 32'(|e.hz_b));
        chk("b_busy", e.cyc, 32'(bus_b.busy_o), 32'(e.busy_b));
        chk("b_stall_cycles", e.cyc, 32'(bus_b.stall_cycles_o), 32'(e.perf_b));
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized stream
  initial begin
    stim_t s;
    stim_t lw5;
    stim_t use1;
    stim_t use2;
    lw5  = mk(1'b1, 1'b1, 5, 1, 0, 1'b1, 1'b0);
    use1 = mk(1'b0, 1'b1, 6, 5, 7, 1'b1, 1'b1);
    use2 = mk(1'b0, 1'b1, 6, 7, 5, 1'b1, 1'b1);

    // Reset held with a load to x5 sitting in ID.
    s = lw5; s.rst_n = 1'b0;
    apply(s); apply(s);
    apply(nop()); apply(nop());

    // Adjacent consumer on rs1, then on rs2.
    apply(lw5);
    for (int i = 0; i < 4; i++) apply(use1);
    apply(nop()); apply(nop()); apply(nop());
    apply(lw5);
    for (int i = 0; i < 4; i++) apply(use2);
    apply(nop()); apply(nop()); apply(nop());

    // Consumer at distance 2 and 4.
    apply(lw5); apply(mk(1'b0, 1'b1, 3, 1, 2, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) apply(use1);
    apply(nop()); apply(nop()); apply(nop());
    apply(lw5); apply(nop()); apply(nop()); apply(nop()); apply(use1);
    apply(nop()); apply(nop());

    // Freeze in the middle of a stall.
    apply(lw5); apply(use1);
    s = use1; s.freeze = 1'b1;
    for (int i = 0; i < 4; i++) apply(s);
    for (int i = 0; i < 3; i++) apply(use1);
    apply(nop()); apply(nop());

    // Flushed load and load to x0 are never recorded.
    s = lw5; s.flush = 1'b1;
    apply(s); apply(use1); apply(use1);
    apply(mk(1'b1, 1'b1, 0, 1, 0, 1'b1, 1'b0));
    apply(mk(1'b0, 1'b1, 6, 0, 0, 1'b1, 1'b1));
    apply(nop());

    // Back-to-back loads to the same register reload the entry.
    apply(lw5); apply(lw5);
    for (int i = 0; i < 5; i++) apply(use1);
    apply(nop()); apply(nop()); apply(nop());

    // Enough stall cycles to saturate the narrow counter.
    for (int k = 0; k < 7; k++) begin
      apply(lw5);
      for (int i = 0; i < 3; i++) apply(use1);
    end
    apply(nop()); apply(nop());

    // Randomized stream over a small register window.
    for (int n = 0; n < 3000; n++) begin
      s        = '0;
      s.rst_n  = ($urandom_range(0, 199) != 0);
      s.valid  = ($urandom_range(0, 9) != 0);
      s.mr     = ($urandom_range(0, 9) < 4);
      s.rw     = ($urandom_range(0, 9) < 8);
      s.rd     = 5'($urandom_range(0, 7));
      s.rs1    = 5'($urandom_range(0, 7));
      s.rs2    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s.u1     = ($urandom_range(0, 3) != 0);
      s.u2     = ($urandom_range(0, 3) != 0);
      s.flush  = ($urandom_range(0, 11) == 0);
      s.freeze = ($urandom_range(0, 9) == 0);
      apply(s);
    end
    apply(nop());

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
